divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 SrcAE  input  32  dividend, sampled only when a start is accepted.
REQ-005 SrcBE  input  32  divisor, sampled only when a start is accepted.
REQ-006 DivE  input  1  start request, level-sampled in IDLE.
REQ-007 DivSgn  input  1  1 = signed (div); 0 = unsigned (divu); sampled with operands.
REQ-008 hi  output  32  remainder, registered.
REQ-009 lo  output  32  quotient, registered.
REQ-010 busy  output  1  high while an operation is in flight.
REQ-011 completed  output  1  one-cycle pulse; hi/lo valid from this cycle.
REQ-012 div_zero  output  1  divisor-was-zero flag; exists only when DIV_ZERO_DETECT_EN is defined.

Function
REQ-013 FSM states SHALL be IDLE, RUN, FIX; reset state is IDLE.
REQ-014 IDLE with DivE=1 at edge N SHALL latch operands, DivSgn and operand signs, clear counter, go to RUN, and set busy.
REQ-015 In signed mode, operand magnitudes SHALL be taken by two's complement before iteration; in unsigned mode operands are used as-is.
REQ-016 RUN SHALL perform one restoring shift-subtract iteration per cycle (33-bit partial remainder; quotient bit = 1 iff subtraction is non-negative) for exactly 32 cycles, then go to FIX.
REQ-017 FIX SHALL apply sign correction, register hi/lo, assert completed for one cycle, clear busy, and return to IDLE.
REQ-018 Latency: completed SHALL be high in cycle N+34 (counted from the sampling edge N); busy SHALL be high in cycles N+1..N+33.
REQ-019 Signed results SHALL truncate toward zero: quotient negated iff operand signs differ, remainder takes the dividend's sign.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 with no exception.
REQ-021 DivE while busy SHALL be ignored; SrcAE/SrcBE/DivSgn changes after acceptance SHALL have no effect.
REQ-022 hi/lo SHALL hold their last result until the next FIX cycle; DivE held high in IDLE after completion SHALL start a new operation.
REQ-023 Without the macro, divide-by-zero SHALL run the full 34 cycles and produce the natural result: unsigned lo=0xFFFFFFFF, hi=SrcAE.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, hi=0, lo=0, busy=0, completed=0, counter=0, and div_zero=0 if present.
REQ-025 Reset mid-operation SHALL abandon the operation; no completed pulse SHALL follow.
REQ-026 rst SHALL take priority over DivE in the same cycle.

Configuration
REQ-027 Macro DIV_ZERO_DETECT_EN defined: when an accepted start has SrcBE=0, the block SHALL skip RUN and go straight to FIX with hi=SrcAE, lo=0xFFFFFFFF, div_zero=1, so completed is high in cycle N+2.
REQ-028 With the macro defined, div_zero SHALL update with each result (1 for zero divisor, 0 otherwise) and hold until the next result.
REQ-029 Macro undefined: the div_zero port and detection logic SHALL be absent, and REQ-023 applies.

Verification
REQ-030 Unsigned 100/7 -> lo=14, hi=2, completed exactly at N+34, busy high N+1..N+33.
REQ-031 Signed 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; signed 7 / 0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; unsigned same operands -> lo=0, hi=0x80000000.
REQ-033 Divisor 0, dividend 0x12345678, unsigned -> hi=0x12345678, lo=0xFFFFFFFF; completed at N+34 without macro, at N+2 with div_zero=1 with macro.
REQ-034 Start 1000/3, assert rst at N+10 -> all outputs 0 next cycle, no completed pulse; then 9/4 -> lo=2, hi=1.
REQ-035 Pulse DivE with new operands at N+5 during 50/5 -> ignored, result lo=10, hi=0, single completed pulse.

Source files
------------

// File: rtl/divider.sv
// 32-bit signed/unsigned restoring divider: hi = remainder, lo = quotient (DIV_ZERO_DETECT_EN adds div_zero and a zero-divisor fast path).
// Latency: completed pulses 34 cycles after the accepting edge (2 cycles for a detected zero divisor).
// Backpressure: no queueing; DivE is only honoured in IDLE and ignored while busy.
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        DivE,
    input  logic        DivSgn,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        completed
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic        div_zero
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dsr;
    logic        r_sgn_a;
    logic        r_sgn_b;
`ifdef DIV_ZERO_DETECT_EN
    logic        r_zero;
`endif

    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_shift;
    logic [32:0] w_sub;
    logic        w_ge;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_mag_a = (DivSgn && SrcAE[31]) ? (32'd0 - SrcAE) : SrcAE;
    assign w_mag_b = (DivSgn && SrcBE[31]) ? (32'd0 - SrcBE) : SrcBE;

    // The dividend shifts out of r_quo's MSB while quotient bits shift in at the LSB.
    assign w_shift = {r_rem[31:0], r_quo[31]};
    assign w_ge    = (w_shift >= {1'b0, r_dsr});
    assign w_sub   = w_shift - {1'b0, r_dsr};

    assign w_quo_fix = (r_sgn_a ^ r_sgn_b) ? (32'd0 - r_quo) : r_quo;
    assign w_rem_fix = r_sgn_a ? (32'd0 - r_rem[31:0]) : r_rem[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 5'd0;
            r_rem     <= 33'd0;
            r_quo     <= 32'd0;
            r_dsr     <= 32'd0;
            r_sgn_a   <= 1'b0;
            r_sgn_b   <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            busy      <= 1'b0;
            completed <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            r_zero    <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            completed <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (DivE) begin
                        r_sgn_a <= DivSgn & SrcAE[31];
                        r_sgn_b <= DivSgn & SrcBE[31];
                        r_quo   <= w_mag_a;
                        r_dsr   <= w_mag_b;
                        r_rem   <= 33'd0;
                        r_cnt   <= 5'd0;
                        busy    <= 1'b1;
                        r_state <= RUN;
`ifdef DIV_ZERO_DETECT_EN
                        r_zero  <= (SrcBE == 32'd0);
                        // Keep the raw dividend so FIX can return it untouched as the remainder.
                        if (SrcBE == 32'd0) begin
                            r_quo   <= SrcAE;
                            r_state <= FIX;
                        end
`endif
                    end
                end
                RUN: begin
                    r_rem <= w_ge ? w_sub : w_shift;
                    r_quo <= {r_quo[30:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
`ifdef DIV_ZERO_DETECT_EN
                    if (r_zero) begin
                        hi <= r_quo;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= w_rem_fix;
                        lo <= w_quo_fix;
                    end
                    div_zero <= r_zero;
`else
                    hi <= w_rem_fix;
                    lo <= w_quo_fix;
`endif
                    completed <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases plus random operands against an arithmetic model.
module tb_divider;

    logic        clk;
    logic        rst;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        DivE;
    logic        DivSgn;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        completed;
`ifdef DIV_ZERO_DETECT_EN
    logic        div_zero;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    int seen;
    logic [31:0] ra, rb;
    logic        rs;

    divider dut (
        .clk       (clk),
        .rst       (rst),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .DivE      (DivE),
        .DivSgn    (DivSgn),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .completed (completed)
`ifdef DIV_ZERO_DETECT_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Truncating division computed in 64 bits so the most-negative / -1 case cannot overflow.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r);
        longint x, y;
        if (b == 32'd0) begin
            r = a;
`ifdef DIV_ZERO_DETECT_EN
            q = 32'hFFFF_FFFF;
`else
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
`endif
        end else begin
            if (sgn) begin
                x = $signed(a);
                y = $signed(b);
            end else begin
                x = {32'd0, a};
                y = {32'd0, b};
            end
            q = 32'(x / y);
            r = 32'(x % y);
        end
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int pulse_at, input string tag);
        logic [31:0] eq, er;
        int l, exp_lat, busy_bad;
        model(a, b, sgn, eq, er);
        exp_lat = 34;
`ifdef DIV_ZERO_DETECT_EN
        if (b == 32'd0) exp_lat = 2;
`endif
        @(negedge clk);
        SrcAE = a; SrcBE = b; DivSgn = sgn; DivE = 1'b1;
        @(negedge clk);
        DivE = 1'b0; SrcAE = $urandom; SrcBE = $urandom; DivSgn = ~sgn;
        l = 1;
        busy_bad = 0;
        while (completed !== 1'b1 && l < 60) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            l++;
            DivE = (l == pulse_at);
            if (l == pulse_at) begin
                SrcAE = $urandom; SrcBE = $urandom_range(1, 9);
            end
        end
        DivE = 1'b0;
        chk({tag, "_latency"}, 32'(l), 32'(exp_lat));
        chk({tag, "_busy_in_flight"}, 32'(busy_bad), 32'd0);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_lo"}, lo, eq);
        chk({tag, "_hi"}, hi, er);
`ifdef DIV_ZERO_DETECT_EN
        chk({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, (b == 32'd0)});
`endif
        @(negedge clk);
        chk({tag, "_single_pulse"}, {31'd0, completed}, 32'd0);
        chk({tag, "_lo_held"}, lo, eq);
    endtask

    initial begin
        rst = 1'b1; DivE = 1'b0; DivSgn = 1'b0; SrcAE = 32'd0; SrcBE = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_completed", {31'd0, completed}, 32'd0);
        // DivE asserted together with reset must not start anything.
        DivE = 1'b1; SrcAE = 32'd5; SrcBE = 32'd1;
        @(negedge clk);
        chk("reset_priority_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0; DivE = 1'b0;

        do_op(32'd100, 32'd7, 1'b0, 0, "u100_7");
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "s_m7_2");
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "s_7_m2");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_min_m1");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "u_min_m1");
        do_op(32'h1234_5678, 32'd0, 1'b0, 0, "u_div0");
        do_op(32'hFFFF_FFFB, 32'd0, 1'b1, 0, "s_div0");
        do_op(32'd50, 32'd5, 1'b0, 5, "busy_ignore");

        // Reset mid-operation abandons it with no completion pulse.
        @(negedge clk);
        SrcAE = 32'd1000; SrcBE = 32'd3; DivSgn = 1'b0; DivE = 1'b1;
        @(negedge clk);
        DivE = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_completed", {31'd0, completed}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (completed === 1'b1 || busy === 1'b1) seen = 1;
        end
        chk("midrst_no_resume", 32'(seen), 32'd0);
        do_op(32'd9, 32'd4, 1'b0, 0, "after_rst");

        // DivE held high: a new operation starts right after the completion cycle.
        @(negedge clk);
        SrcAE = 32'd20; SrcBE = 32'd6; DivSgn = 1'b0; DivE = 1'b1;
        lat = 0;
        while (completed !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_lat", 32'(lat), 32'd34);
        chk("hold_lo1", lo, 32'd3);
        chk("hold_hi1", hi, 32'd2);
        @(negedge clk);
        chk("hold_restart_busy", {31'd0, busy}, 32'd1);
        DivE = 1'b0;
        lat = 0;
        while (completed !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_lat2", 32'(lat), 32'd33);
        chk("hold_lo2", lo, 32'd3);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(1, 15);
                1:       rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: rb = $urandom;
            endcase
            if (rb == 32'd0) rb = 32'd1;
            rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs, 0, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
